oe_config_loader: RTL and testbench
===================================

OE_CONFIG_LOADER -- requirements
Module: oe_config_loader

Interface
REQ-001 SHALL have parameter NUM_MC, default 16: number of macrocells whose output-enable mux select is configured; legal range 2..64.
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-004 SHALL have port cfg_start, input, 1: begin a new load sequence.
REQ-005 SHALL have port cfg_valid, input, 1: cfg_data holds a field.
REQ-006 SHALL have port cfg_data, input, [0:2]: one 3-bit oe_mux select field.
REQ-007 SHALL have port cfg_ready, output, 1: loader accepts a field this cycle.
REQ-008 SHALL have port cfg_busy, output, 1: high in LOAD or COMMIT.
REQ-009 SHALL have port cfg_done, output, 1: one-cycle pulse when the new configuration becomes active.
REQ-010 SHALL have port cfg_loaded, output, 1: sticky; at least one commit since reset.
REQ-011 SHALL have port oe_mux_bus, output, [0:3*NUM_MC-1]: active selects; macrocell i occupies bits [3i:3i+2], bit order matching the per-macrocell oe_mux[0:2].

Function
REQ-012 SHALL implement a three-state FSM: IDLE, LOAD, COMMIT.
REQ-013 SHALL hold a shadow register of 3*NUM_MC bits, an active register driving oe_mux_bus, and a beat counter of width clog2(NUM_MC).
REQ-014 IDLE: cfg_ready=0; cfg_valid ignored; cfg_start=1 -> LOAD, counter<=0.
REQ-015 LOAD: cfg_ready=1; a beat is accepted when cfg_valid&cfg_ready; the accepted cfg_data SHALL be written to shadow field [counter], then counter<=counter+1.
REQ-016 LOAD: the beat accepted with counter==NUM_MC-1 SHALL move the FSM to COMMIT; the counter SHALL NOT wrap past NUM_MC-1.
REQ-017 LOAD, cfg_start=1 (with or without cfg_valid) -> counter<=0, stay in LOAD, and any same-cycle beat discarded; fields already written remain in shadow but are overwritten by the restarted sequence.
REQ-018 COMMIT: cfg_ready=0; on the next edge active<=shadow, cfg_done<=1 for exactly one cycle, cfg_loaded<=1, FSM->IDLE.
REQ-019 COMMIT: cfg_start and cfg_valid SHALL be ignored; a restart request SHALL be reissued from IDLE.
REQ-020 Latency: last beat accepted at edge E -> oe_mux_bus updated and cfg_done high after edge E+1.
REQ-021 oe_mux_bus SHALL change only at the COMMIT edge; partial or aborted loads never alter it.
REQ-022 cfg_busy SHALL be combinational from FSM state; cfg_done, cfg_loaded and oe_mux_bus SHALL be registered.
REQ-023 Field values SHALL be stored unmodified; all 8 codes, including 000 (disabled) and 111 (product-term enable), are legal.

Reset
REQ-024 rst_n low SHALL immediately force: FSM=IDLE, counter=0, shadow=0, oe_mux_bus=0 (all outputs disabled), cfg_done=0, cfg_loaded=0, cfg_ready=0, cfg_busy=0.
REQ-025 Reset asserted during LOAD or COMMIT SHALL abort with no commit; the first cycle after release SHALL be IDLE.

Verification
REQ-026 Full load, NUM_MC=16: start, then 16 beats with field i = i mod 8 -> cfg_done is one pulse one cycle after the last beat's edge; oe_mux_bus[3i:3i+2] = i mod 8; cfg_loaded=1.
REQ-027 Backpressure gaps: cfg_valid toggles 1/0 each cycle over 16 beats -> same final bus as REQ-026; cfg_done occurs once.
REQ-028 Restart: after 5 beats of 3'b111, start, then 16 beats of 3'b001 -> bus all 3'b001; the bus held its prior value throughout.
REQ-029 Ignored traffic: cfg_valid=1 with data 3'b101 in IDLE, and start asserted in COMMIT -> no shadow write, no extra LOAD, a single cfg_done.
REQ-030 Reset mid-load: after commit of all 3'b010, start, 8 beats, rst_n low for 1 cycle -> bus=0, cfg_loaded=0, FSM IDLE, cfg_done never pulses.
REQ-031 Boundary, NUM_MC=2: start, 2 beats (3'b110, 3'b011) -> oe_mux_bus=6'b110011; the counter does not exceed 1.

Source files
------------

// File: rtl/oe_config_loader.sv
// Loads one 3-bit output-enable mux select per macrocell through a valid/ready beat stream
// into a shadow register, then commits the whole set atomically to the active select bus.
module oe_config_loader #(
    parameter int NUM_MC = 16  // legal range 2..64
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cfg_start,
    input  logic                cfg_valid,
    input  logic [0:2]          cfg_data,
    output logic                cfg_ready,
    output logic                cfg_busy,
    output logic                cfg_done,
    output logic                cfg_loaded,
    output logic [0:3*NUM_MC-1] oe_mux_bus
);

    localparam int               CNT_W = $clog2(NUM_MC);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(NUM_MC - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        COMMIT = 2'd2
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [CNT_W-1:0]    cnt;
    logic [0:3*NUM_MC-1] shadow;
    logic                beat;
    logic                restart;

    // A start in LOAD takes priority over a same-cycle beat, which is dropped.
    always_comb begin
        state_nxt = state;
        cfg_ready = 1'b0;
        beat      = 1'b0;
        restart   = 1'b0;
        case (state)
            IDLE: begin
                if (cfg_start) begin
                    state_nxt = LOAD;
                    restart   = 1'b1;
                end
            end
            LOAD: begin
                cfg_ready = 1'b1;
                restart   = cfg_start;
                beat      = cfg_valid & ~cfg_start;
                if (beat && (cnt == LAST)) begin
                    state_nxt = COMMIT;
                end
            end
            COMMIT: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign cfg_busy = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // The counter saturates at the last field; only a restart brings it back to zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            shadow <= '0;
        end else if (restart) begin
            cnt <= '0;
        end else if (beat) begin
            for (int i = 0; i < NUM_MC; i++) begin
                if (cnt == CNT_W'(i)) begin
                    shadow[3*i +: 3] <= cfg_data;
                end
            end
            if (cnt != LAST) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    // The active bus moves only on the commit edge, so partial loads never reach it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            oe_mux_bus <= '0;
            cfg_done   <= 1'b0;
            cfg_loaded <= 1'b0;
        end else begin
            cfg_done <= (state == COMMIT);
            if (state == COMMIT) begin
                oe_mux_bus <= shadow;
                cfg_loaded <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_oe_config_loader.sv
// Randomized and directed bench for oe_config_loader with a 16-macrocell and a 2-macrocell
// instance, scored against a sequence-level reference model through expected-bus queues.
module tb_oe_config_loader;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       st[2];
    logic       vl[2];
    logic [2:0] dt[2];

    logic       ready_w[2];
    logic       busy_w[2];
    logic       done_w[2];
    logic       loaded_w[2];
    logic [0:47] bus0;
    logic [0:5]  bus1;
    logic [0:47] bus_w[2];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    oe_config_loader #(.NUM_MC(16)) u_mc16 (
        .clk(clk), .rst_n(rst_n), .cfg_start(st[0]), .cfg_valid(vl[0]), .cfg_data(dt[0]),
        .cfg_ready(ready_w[0]), .cfg_busy(busy_w[0]), .cfg_done(done_w[0]),
        .cfg_loaded(loaded_w[0]), .oe_mux_bus(bus0)
    );

    oe_config_loader #(.NUM_MC(2)) u_mc2 (
        .clk(clk), .rst_n(rst_n), .cfg_start(st[1]), .cfg_valid(vl[1]), .cfg_data(dt[1]),
        .cfg_ready(ready_w[1]), .cfg_busy(busy_w[1]), .cfg_done(done_w[1]),
        .cfg_loaded(loaded_w[1]), .oe_mux_bus(bus1)
    );

    assign bus_w[0] = bus0;
    assign bus_w[1] = {bus1, 42'b0};

    // Reference model: a load is the list of accepted fields since the last start;
    // once it holds NUM_MC fields the packed bus is queued and appears one edge later.
    localparam int P_IDLE = 0, P_LOAD = 1, P_COMMIT = 2;
    int          phase[2]   = '{P_IDLE, P_IDLE};
    int          pcnt[2]    = '{0, 0};
    bit   [2:0]  pend[2][16];
    bit          mdone[2]   = '{1'b0, 1'b0};
    bit          mloaded[2] = '{1'b0, 1'b0};
    logic [0:47] held[2]    = '{48'b0, 48'b0};
    logic [0:47] q0[$];
    logic [0:47] q1[$];

    function automatic int nmc(int k);
        return (k == 0) ? 16 : 2;
    endfunction

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_step(int k);
        logic [0:47] b;
        mdone[k] = 1'b0;
        case (phase[k])
            P_IDLE: begin
                if (st[k]) begin
                    phase[k] = P_LOAD;
                    pcnt[k]  = 0;
                end
            end
            P_LOAD: begin
                if (st[k]) begin
                    pcnt[k] = 0;
                end else if (vl[k]) begin
                    pend[k][pcnt[k]] = dt[k];
                    pcnt[k]++;
                    if (pcnt[k] == nmc(k)) begin
                        b = '0;
                        for (int i = 0; i < nmc(k); i++) b[3*i +: 3] = pend[k][i];
                        if (k == 0) q0.push_back(b);
                        else        q1.push_back(b);
                        phase[k] = P_COMMIT;
                    end
                end
            end
            default: begin
                mdone[k]   = 1'b1;
                mloaded[k] = 1'b1;
                phase[k]   = P_IDLE;
            end
        endcase
    endtask

    always @(posedge clk) begin
        if (rst_n === 1'b1) begin
            model_step(0);
            model_step(1);
        end
    end

    always @(negedge rst_n) begin
        for (int k = 0; k < 2; k++) begin
            phase[k]   = P_IDLE;
            pcnt[k]    = 0;
            mdone[k]   = 1'b0;
            mloaded[k] = 1'b0;
            held[k]    = '0;
            for (int i = 0; i < 16; i++) pend[k][i] = 3'b000;
        end
        q0.delete();
        q1.delete();
    end

    // Monitor: every falling edge compare both instances against the model.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (mdone[k]) begin
                if (k == 0 && q0.size() > 0) held[k] = q0.pop_front();
                if (k == 1 && q1.size() > 0) held[k] = q1.pop_front();
            end
            chk($sformatf("done%0d", k),   64'(done_w[k]),   64'(mdone[k]));
            chk($sformatf("loaded%0d", k), 64'(loaded_w[k]), 64'(mloaded[k]));
            chk($sformatf("ready%0d", k),  64'(ready_w[k]),  64'(phase[k] == P_LOAD));
            chk($sformatf("busy%0d", k),   64'(busy_w[k]),   64'(phase[k] != P_IDLE));
            chk($sformatf("bus%0d", k),    64'(bus_w[k]),    64'(held[k]));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start(int k);
        st[k] = 1'b1;
        tick();
        st[k] = 1'b0;
    endtask

    task automatic beat(int k, logic [2:0] d);
        vl[k] = 1'b1;
        dt[k] = d;
        tick();
        vl[k] = 1'b0;
    endtask

    task automatic rand_load(int k);
        int c = 0;
        int restarts = 0;
        for (int j = 0; j < 2; j++) begin
            vl[k] = 1'($urandom);
            dt[k] = 3'($urandom);
            tick();
        end
        st[k] = 1'b1;
        tick();
        st[k] = 1'b0;
        while (c < nmc(k)) begin
            dt[k] = 3'($urandom);
            if (restarts < 2 && $urandom_range(0, 19) == 0) begin
                st[k] = 1'b1;
                vl[k] = 1'($urandom);
                c = 0;
                restarts++;
            end else begin
                st[k] = 1'b0;
                vl[k] = ($urandom_range(0, 9) < 7);
                if (vl[k]) c++;
            end
            tick();
        end
        st[k] = 1'($urandom);
        vl[k] = 1'($urandom);
        dt[k] = 3'($urandom);
        tick();
        st[k] = 1'b0;
        vl[k] = 1'b0;
        tick();
    endtask

    initial begin
        rst_n = 1'b0;
        for (int k = 0; k < 2; k++) begin
            st[k] = 1'b0;
            vl[k] = 1'b0;
            dt[k] = 3'b000;
        end
        tick();
        tick();
        chk("reset_bus", 64'(bus0), 64'd0);
        chk("reset_loaded", 64'(loaded_w[0]), 64'd0);
        rst_n = 1'b1;
        tick();

        // Full load with field i = i mod 8.
        start(0);
        for (int i = 0; i < 16; i++) beat(0, 3'(i % 8));
        tick();
        tick();
        for (int i = 0; i < 16; i++) chk($sformatf("full_f%0d", i), 64'(bus0[3*i +: 3]), 64'(i % 8));
        chk("full_loaded", 64'(loaded_w[0]), 64'd1);

        // Alternating valid gaps.
        start(0);
        for (int i = 0; i < 32; i++) begin
            vl[0] = ~i[0];
            dt[0] = 3'((i / 2) % 8);
            tick();
        end
        vl[0] = 1'b0;
        tick();
        tick();

        // Restart after partial load of 111s.
        start(0);
        for (int i = 0; i < 5; i++) beat(0, 3'b111);
        start(0);
        for (int i = 0; i < 16; i++) beat(0, 3'b001);
        tick();
        tick();
        chk("restart_bus", 64'(bus0), 64'h249249249249);

        // Valid in IDLE and start during COMMIT are ignored.
        vl[0] = 1'b1;
        dt[0] = 3'b101;
        tick();
        tick();
        tick();
        vl[0] = 1'b0;
        start(0);
        for (int i = 0; i < 16; i++) beat(0, 3'b100);
        st[0] = 1'b1;
        vl[0] = 1'b1;
        dt[0] = 3'b101;
        tick();
        st[0] = 1'b0;
        vl[0] = 1'b0;
        tick();
        tick();
        chk("ignored_busy", 64'(busy_w[0]), 64'd0);

        // Reset in the middle of a load.
        start(0);
        for (int i = 0; i < 16; i++) beat(0, 3'b010);
        tick();
        tick();
        start(0);
        for (int i = 0; i < 8; i++) beat(0, 3'($urandom));
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("rst_bus", 64'(bus0), 64'd0);
        chk("rst_loaded", 64'(loaded_w[0]), 64'd0);
        chk("rst_busy", 64'(busy_w[0]), 64'd0);
        tick();
        tick();

        // Two-macrocell boundary.
        start(1);
        beat(1, 3'b110);
        beat(1, 3'b011);
        tick();
        tick();
        chk("mc2_bus", 64'(bus1), 64'(6'b110011));
        beat(1, 3'b111);
        tick();
        chk("mc2_hold", 64'(bus1), 64'(6'b110011));

        for (int n = 0; n < 40; n++) rand_load(n % 2);

        tick();
        chk("q0_empty", 64'(q0.size()), 64'd0);
        chk("q1_empty", 64'(q1.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
